cpu_io_bridge: RTL and testbench
================================

CPU_IO_BRIDGE -- requirements
Module: cpu_io_bridge

Interface
REQ-001 Parameter DATA_W, default 16, SHALL set the CPU/peripheral word width.
REQ-002 Parameter DEPTH, default 4, SHALL set the entry count of each FIFO; it SHALL be a power of two and at least 2.
REQ-003 Parameter HOLDOFF, default 2, SHALL set the number of cycles interrupt stays low after an acknowledge.
REQ-004 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 cpu_data_out  input  DATA_W  write word from the core.
REQ-007 cpu_wr  input  1  core write strobe; one word per high cycle.
REQ-008 cpu_rd  input  1  core read/acknowledge strobe; one word per high cycle.
REQ-009 cpu_data_in  output  DATA_W  word presented to the core's data_in.
REQ-010 interrupt  output  1  interrupt request to the core.
REQ-011 ext_in_data / ext_in_valid / ext_in_ready  input / input / output  DATA_W/1/1  peripheral-to-core valid/ready stream.
REQ-012 ext_out_data / ext_out_valid / ext_out_ready  output / output / input  DATA_W/1/1  core-to-peripheral valid/ready stream.
REQ-013 tx_overflow  output  1  sticky flag: a core write was dropped.
REQ-014 rx_underflow  output  1  sticky flag: a core read hit an empty RX FIFO.

Function
REQ-015 RX FIFO: ext_in_ready SHALL equal !rx_full, and a word SHALL be pushed on a clock edge where ext_in_valid and ext_in_ready are both high.
REQ-016 cpu_data_in SHALL combinationally show the RX head word when the RX FIFO is non-empty, and 0 when it is empty.
REQ-017 cpu_rd with RX non-empty SHALL pop one word; cpu_rd with RX empty SHALL leave the FIFO unchanged and set rx_underflow.
REQ-018 TX FIFO: cpu_wr with TX not full (evaluated before the edge) SHALL push cpu_data_out.
REQ-019 cpu_wr with TX full SHALL drop the word and set tx_overflow, even if a pop occurs in the same cycle.
REQ-020 ext_out_valid SHALL equal !tx_empty, ext_out_data SHALL be the TX head word, and a pop SHALL occur on an edge with ext_out_valid and ext_out_ready both high.
REQ-021 A simultaneous push and pop on a non-full, non-empty FIFO SHALL leave its count unchanged.
REQ-022 Both FIFOs SHALL preserve order, and their pointers SHALL wrap modulo DEPTH.
REQ-023 Interrupt FSM states SHALL be IDLE, PEND and HOLD, with interrupt registered and high only in PEND.
REQ-024 IDLE SHALL go to PEND on the edge where RX count is non-zero, so interrupt rises 2 edges after the first RX handshake edge.
REQ-025 PEND SHALL go to HOLD on the edge where cpu_rd pops a word, with interrupt low from that edge.
REQ-026 HOLD SHALL count HOLDOFF cycles and then return to IDLE, re-entering PEND if RX is still non-empty.
REQ-027 cpu_rd in IDLE or HOLD (polling) SHALL pop normally and SHALL NOT change state.
REQ-028 Sticky flags SHALL clear only on reset.

Reset
REQ-029 While reset is high, both FIFOs SHALL be emptied, the FSM SHALL be in IDLE and the holdoff counter cleared, asynchronously.
REQ-030 During reset, interrupt, ext_out_valid, tx_overflow and rx_underflow SHALL be 0, ext_in_ready SHALL be 0, and cpu_data_in SHALL be 0.
REQ-031 Reset asserted mid-transfer SHALL discard all buffered words; no partial word SHALL appear after release.
REQ-032 After release, ext_in_ready SHALL be 1.

Structure
REQ-033 A shared package SHALL hold DATA_W, DEPTH and HOLDOFF defaults and the FSM state encoding.
REQ-034 A single sub-module io_fifo (width, depth, push, pop, full, empty, count, head) SHALL be instantiated twice, once for RX and once for TX.

Verification
REQ-035 Push ext_in 0x1234 with no cpu_rd -> cpu_data_in=0x1234 after that edge, interrupt high 2 edges after the handshake, and interrupt held high.
REQ-036 With 0xAAAA and 0xBBBB in RX, cpu_rd in PEND -> interrupt low for 2 cycles, then high again with cpu_data_in=0xBBBB.
REQ-037 5 cpu_wr of 1..5 with ext_out_ready=0 -> ext_out holds 1..4, the 5th is dropped, and tx_overflow=1; then ready=1 -> 1,2,3,4 emitted in order.
REQ-038 cpu_rd with RX empty -> rx_underflow=1, cpu_data_in=0, and the FSM stays IDLE.
REQ-039 Fill RX to 4 -> ext_in_ready=0; a valid 5th word is not taken; one cpu_rd -> ext_in_ready=1 next cycle.
REQ-040 Assert reset while interrupt is high and TX holds 3 words -> interrupt=0, ext_out_valid=0, both flags 0, and 0 words remain after release.

Source files
------------

// File: rtl/cpu_io_bridge_pkg.sv
// Shared defaults and interrupt FSM encoding for the CPU I/O bridge.
package cpu_io_bridge_pkg;

  localparam int unsigned DataWDef   = 16;
  localparam int unsigned DepthDef   = 4;
  localparam int unsigned HoldoffDef = 2;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StPend = 2'd1,
    StHold = 2'd2
  } irq_state_e;

endpackage

// File: rtl/cpu_io_bridge_if.sv
// Core-side strobes and peripheral-side valid/ready streams of the bridge.
interface cpu_io_bridge_if
  import cpu_io_bridge_pkg::*;
#(
  parameter int unsigned DATA_W = DataWDef
);

  logic [DATA_W-1:0] cpu_data_out;
  logic              cpu_wr;
  logic              cpu_rd;
  logic [DATA_W-1:0] cpu_data_in;
  logic              interrupt;
  logic [DATA_W-1:0] ext_in_data;
  logic              ext_in_valid;
  logic              ext_in_ready;
  logic [DATA_W-1:0] ext_out_data;
  logic              ext_out_valid;
  logic              ext_out_ready;
  logic              tx_overflow;
  logic              rx_underflow;

  // Environment side: drives core strobes and peripheral streams.
  modport master (
    output cpu_data_out, cpu_wr, cpu_rd, ext_in_data, ext_in_valid, ext_out_ready,
    input  cpu_data_in, interrupt, ext_in_ready, ext_out_data, ext_out_valid,
           tx_overflow, rx_underflow
  );

  // Bridge side.
  modport slave (
    input  cpu_data_out, cpu_wr, cpu_rd, ext_in_data, ext_in_valid, ext_out_ready,
    output cpu_data_in, interrupt, ext_in_ready, ext_out_data, ext_out_valid,
           tx_overflow, rx_underflow
  );

endinterface

// File: rtl/cpu_io_bridge_io_fifo.sv
// Synchronous FIFO with head-of-queue output; pointers wrap modulo Depth (power of two).
module io_fifo #(
  parameter int unsigned Width = 16,
  parameter int unsigned Depth = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic [Width-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(Depth+1)-1:0] count_o,
  output logic [Width-1:0]           head_o
);

  localparam int unsigned AddrW = $clog2(Depth);
  localparam int unsigned CntW  = $clog2(Depth + 1);
  localparam logic [AddrW-1:0] PtrOne  = 1;
  localparam logic [CntW-1:0]  CntOne  = 1;
  localparam logic [CntW-1:0]  CntFull = CntW'(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [AddrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CntFull);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // Accept/remove words only when legal as seen before the edge.
  always_comb begin
    do_push  = push_i && !full_o;
    do_pop   = pop_i && !empty_o;
    wr_ptr_d = do_push ? wr_ptr_q + PtrOne : wr_ptr_q;
    rd_ptr_d = do_pop ? rd_ptr_q + PtrOne : rd_ptr_q;
    count_d  = count_q;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CntOne;
      2'b01:   count_d = count_q - CntOne;
      default: count_d = count_q;
    endcase
  end

  // Storage and pointer registers; reset empties the queue.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/cpu_io_bridge.sv
// CPU <-> peripheral bridge: RX/TX FIFOs, sticky error flags and an interrupt
// FSM with a post-acknowledge holdoff.
module cpu_io_bridge
  import cpu_io_bridge_pkg::*;
#(
  parameter int unsigned DATA_W  = DataWDef,
  parameter int unsigned DEPTH   = DepthDef,
  parameter int unsigned HOLDOFF = HoldoffDef
) (
  input  logic           clk,
  input  logic           reset,
  cpu_io_bridge_if.slave bus
);

  localparam int unsigned CntW  = $clog2(DEPTH + 1);
  localparam int unsigned HoldW = $clog2(HOLDOFF + 1);
  localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLDOFF - 1);
  localparam logic [HoldW-1:0] HoldOne  = 1;

  logic              rx_full, rx_empty, tx_full, tx_empty;
  logic [CntW-1:0]   rx_count, tx_count;
  logic [DATA_W-1:0] rx_head, tx_head;
  logic              rx_pop_fire;
  logic              unused_cnt;

  irq_state_e        state_q, state_d;
  logic [HoldW-1:0]  hold_cnt_q, hold_cnt_d;
  logic              tx_ovf_q, rx_unf_q;

  // Occupancy is implied by empty/full; counts are kept for the interface only.
  assign unused_cnt = ^{rx_count, tx_count};

  io_fifo #(.Width(DATA_W), .Depth(DEPTH)) u_rx_fifo (
    .clk_i   (clk),
    .rst_i   (reset),
    .push_i  (bus.ext_in_valid && bus.ext_in_ready),
    .wdata_i (bus.ext_in_data),
    .pop_i   (bus.cpu_rd),
    .full_o  (rx_full),
    .empty_o (rx_empty),
    .count_o (rx_count),
    .head_o  (rx_head)
  );

  io_fifo #(.Width(DATA_W), .Depth(DEPTH)) u_tx_fifo (
    .clk_i   (clk),
    .rst_i   (reset),
    .push_i  (bus.cpu_wr),
    .wdata_i (bus.cpu_data_out),
    .pop_i   (bus.ext_out_ready),
    .full_o  (tx_full),
    .empty_o (tx_empty),
    .count_o (tx_count),
    .head_o  (tx_head)
  );

  // Ready is masked during reset so nothing is offered while the FIFO is held empty.
  assign bus.ext_in_ready  = !rx_full && !reset;
  assign bus.cpu_data_in   = rx_empty ? '0 : rx_head;
  assign bus.ext_out_valid = !tx_empty;
  assign bus.ext_out_data  = tx_head;
  assign bus.interrupt     = (state_q == StPend);
  assign bus.tx_overflow   = tx_ovf_q;
  assign bus.rx_underflow  = rx_unf_q;
  assign rx_pop_fire       = bus.cpu_rd && !rx_empty;

  // Interrupt next-state: raise on data, drop on acknowledge, hold off HOLDOFF cycles.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    unique case (state_q)
      StIdle: if (!rx_empty) state_d = StPend;
      StPend: begin
        if (rx_pop_fire) begin
          state_d    = StHold;
          hold_cnt_d = '0;
        end
      end
      StHold: begin
        if (hold_cnt_q == HoldLast) begin
          state_d    = rx_empty ? StIdle : StPend;
          hold_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + HoldOne;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM, holdoff counter and sticky error flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      hold_cnt_q <= '0;
      tx_ovf_q   <= 1'b0;
      rx_unf_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      tx_ovf_q   <= tx_ovf_q | (bus.cpu_wr && tx_full);
      rx_unf_q   <= rx_unf_q | (bus.cpu_rd && rx_empty);
    end
  end

endmodule

// File: tb/tb_cpu_io_bridge.sv
// Randomized and directed bench for cpu_io_bridge against a queue-based model.
module tb_cpu_io_bridge;
  import cpu_io_bridge_pkg::*;

  localparam int unsigned DW  = DataWDef;
  localparam int unsigned DEP = DepthDef;
  localparam int unsigned HO  = HoldoffDef;

  logic clk = 1'b0;
  logic reset;

  cpu_io_bridge_if #(.DATA_W(DW)) bus ();

  cpu_io_bridge #(.DATA_W(DW), .DEPTH(DEP), .HOLDOFF(HO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: word queues, sticky flags, interrupt pending and holdoff timer.
  logic [DW-1:0] m_rx[$];
  logic [DW-1:0] m_tx[$];
  bit m_ovf, m_unf, m_pend;
  int m_hold;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_rx.delete();
    m_tx.delete();
    m_ovf  = 0;
    m_unf  = 0;
    m_pend = 0;
    m_hold = 0;
  endtask

  task automatic check_outputs(input string tag);
    check_val({tag, "_cpu_data_in"}, 32'(bus.cpu_data_in), (m_rx.size() != 0) ? 32'(m_rx[0]) : 32'd0);
    check_val({tag, "_interrupt"}, 32'(bus.interrupt), 32'(m_pend));
    check_val({tag, "_in_ready"}, 32'(bus.ext_in_ready), 32'(m_rx.size() < DEP));
    check_val({tag, "_out_valid"}, 32'(bus.ext_out_valid), 32'(m_tx.size() != 0));
    if (m_tx.size() != 0) check_val({tag, "_out_data"}, 32'(bus.ext_out_data), 32'(m_tx[0]));
    check_val({tag, "_tx_overflow"}, 32'(bus.tx_overflow), 32'(m_ovf));
    check_val({tag, "_rx_underflow"}, 32'(bus.rx_underflow), 32'(m_unf));
  endtask

  task automatic drive_idle();
    bus.cpu_data_out  = '0;
    bus.cpu_wr        = 1'b0;
    bus.cpu_rd        = 1'b0;
    bus.ext_in_data   = '0;
    bus.ext_in_valid  = 1'b0;
    bus.ext_out_ready = 1'b0;
  endtask

  // One clock: drive at negedge, advance the model with pre-edge state, check at next negedge.
  task automatic cycle(input string tag, input bit in_v, input logic [DW-1:0] in_d,
                       input bit out_r, input bit wr, input logic [DW-1:0] wd, input bit rd);
    bit rx_empty, rx_full, tx_empty, tx_full;
    bus.ext_in_valid  = in_v;
    bus.ext_in_data   = in_d;
    bus.ext_out_ready = out_r;
    bus.cpu_wr        = wr;
    bus.cpu_data_out  = wd;
    bus.cpu_rd        = rd;
    rx_empty = (m_rx.size() == 0);
    rx_full  = (m_rx.size() == DEP);
    tx_empty = (m_tx.size() == 0);
    tx_full  = (m_tx.size() == DEP);
    if (m_hold > 0) begin
      m_hold--;
      if (m_hold == 0) m_pend = !rx_empty;
    end else if (m_pend) begin
      if (rd && !rx_empty) begin
        m_pend = 0;
        m_hold = HO;
      end
    end else begin
      m_pend = !rx_empty;
    end
    if (rd) begin
      if (!rx_empty) void'(m_rx.pop_front());
      else m_unf = 1;
    end
    if (in_v && !rx_full) m_rx.push_back(in_d);
    if (out_r && !tx_empty) void'(m_tx.pop_front());
    if (wr) begin
      if (!tx_full) m_tx.push_back(wd);
      else m_ovf = 1;
    end
    @(posedge clk);
    @(negedge clk);
    drive_idle();
    check_outputs(tag);
  endtask

  task automatic idle_cycle(input string tag);
    cycle(tag, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  // Asynchronous reset pulse away from the clock edge, with checks while it is held.
  task automatic do_reset(input string tag);
    drive_idle();
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check_val({tag, "_rst_interrupt"}, 32'(bus.interrupt), 32'd0);
    check_val({tag, "_rst_out_valid"}, 32'(bus.ext_out_valid), 32'd0);
    check_val({tag, "_rst_in_ready"}, 32'(bus.ext_in_ready), 32'd0);
    check_val({tag, "_rst_cpu_data_in"}, 32'(bus.cpu_data_in), 32'd0);
    check_val({tag, "_rst_flags"}, {30'd0, bus.tx_overflow, bus.rx_underflow}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    #1;
    check_outputs({tag, "_post"});
    check_val({tag, "_post_in_ready"}, 32'(bus.ext_in_ready), 32'd1);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    drive_idle();
    model_reset();
    repeat (2) @(negedge clk);
    check_val("init_interrupt", 32'(bus.interrupt), 32'd0);
    check_val("init_in_ready", 32'(bus.ext_in_ready), 32'd0);
    check_val("init_out_valid", 32'(bus.ext_out_valid), 32'd0);
    reset = 1'b0;
    #1;
    check_val("init_release_ready", 32'(bus.ext_in_ready), 32'd1);
    @(negedge clk);

    // Single RX word raises and holds the interrupt.
    cycle("r035_push", 1'b1, 16'h1234, 1'b0, 1'b0, '0, 1'b0);
    check_val("r035_data", 32'(bus.cpu_data_in), 32'h1234);
    check_val("r035_irq_early", 32'(bus.interrupt), 32'd0);
    idle_cycle("r035_wait");
    check_val("r035_irq_high", 32'(bus.interrupt), 32'd1);
    idle_cycle("r035_hold");
    check_val("r035_irq_held", 32'(bus.interrupt), 32'd1);

    // Acknowledge with a second word pending: holdoff then re-raise.
    do_reset("r036");
    cycle("r036_a", 1'b1, 16'hAAAA, 1'b0, 1'b0, '0, 1'b0);
    cycle("r036_b", 1'b1, 16'hBBBB, 1'b0, 1'b0, '0, 1'b0);
    check_val("r036_irq_pend", 32'(bus.interrupt), 32'd1);
    cycle("r036_ack", 1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
    check_val("r036_irq_low1", 32'(bus.interrupt), 32'd0);
    check_val("r036_data", 32'(bus.cpu_data_in), 32'hBBBB);
    idle_cycle("r036_h1");
    check_val("r036_irq_low2", 32'(bus.interrupt), 32'd0);
    idle_cycle("r036_h2");
    check_val("r036_irq_again", 32'(bus.interrupt), 32'd1);
    check_val("r036_data_again", 32'(bus.cpu_data_in), 32'hBBBB);

    // TX overflow drops the fifth word; the rest drain in order.
    do_reset("r037");
    for (int i = 1; i <= 5; i++) cycle("r037_wr", 1'b0, '0, 1'b0, 1'b1, DW'(i), 1'b0);
    check_val("r037_overflow", 32'(bus.tx_overflow), 32'd1);
    for (int i = 1; i <= 4; i++) begin
      check_val("r037_order", 32'(bus.ext_out_data), 32'(i));
      cycle("r037_drain", 1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
    end
    check_val("r037_empty", 32'(bus.ext_out_valid), 32'd0);

    // Read from an empty RX FIFO.
    do_reset("r038");
    cycle("r038_rd", 1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
    check_val("r038_underflow", 32'(bus.rx_underflow), 32'd1);
    check_val("r038_data", 32'(bus.cpu_data_in), 32'd0);
    idle_cycle("r038_idle");
    check_val("r038_irq", 32'(bus.interrupt), 32'd0);

    // Full RX back-pressure.
    do_reset("r039");
    for (int i = 0; i < int'(DEP); i++) cycle("r039_fill", 1'b1, DW'(16'h100 + i), 1'b0, 1'b0, '0, 1'b0);
    check_val("r039_not_ready", 32'(bus.ext_in_ready), 32'd0);
    cycle("r039_5th", 1'b1, 16'h5555, 1'b0, 1'b0, '0, 1'b0);
    check_val("r039_still_full", 32'(bus.ext_in_ready), 32'd0);
    cycle("r039_rd", 1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
    check_val("r039_ready_again", 32'(bus.ext_in_ready), 32'd1);
    check_val("r039_head", 32'(bus.cpu_data_in), 32'h101);

    // Reset mid-transfer with interrupt high and three TX words buffered.
    do_reset("r040");
    cycle("r040_rx", 1'b1, 16'h0042, 1'b0, 1'b0, '0, 1'b0);
    for (int i = 0; i < 3; i++) cycle("r040_tx", 1'b0, '0, 1'b0, 1'b1, DW'(16'h70 + i), 1'b0);
    check_val("r040_irq_before", 32'(bus.interrupt), 32'd1);
    do_reset("r040");
    check_val("r040_out_valid", 32'(bus.ext_out_valid), 32'd0);
    check_val("r040_cpu_data_in", 32'(bus.cpu_data_in), 32'd0);

    // Randomized traffic with an occasional mid-run reset.
    for (int i = 0; i < 600; i++) begin
      if (i == 300) do_reset("rnd");
      cycle("rnd", ($urandom_range(0, 99) < 50), DW'($urandom),
            ($urandom_range(0, 99) < 40), ($urandom_range(0, 99) < 40), DW'($urandom),
            ($urandom_range(0, 99) < 30));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
